// File: rtl/alu_tx_pkg.sv
// Shared types and constants for the ALU result UART transmitter.
// State encoding, frame width and uo_out bit positions.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int TX_BIT    = 0;
  localparam int BUSY_BIT  = 1;
  localparam int DONE_BIT  = 2;

endpackage

// File: rtl/tt_um_alu_uart_tx_start_sync.sv
// Start pin synchronizer with rising-edge detection.
// Two flops for metastability, a third holds the previous level.
module start_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], pin};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/tt_um_alu_uart_tx.sv
// Serial transmitter for one ALU result byte, 8N1 or 8E1.
// All outputs come straight from registers.
module tt_um_alu_uart_tx
  import alu_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state;
  logic [7:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] data_q;
  logic       par_q;
  logic       tx;
  logic       busy;
  logic       done;
  logic       start_rise;
  logic       bit_end;
  logic       unused_ok;

  assign unused_ok = ^{ena, uio_in[7:2]};

  start_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (uio_in[0]),
    .rise  (start_rise)
  );

  assign bit_end = (baud == BAUD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud <= '0;
    end else if (state == S_IDLE || bit_end) begin
      baud <= '0;
    end else begin
      baud <= baud + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_rise) begin
            state  <= S_START;
            data_q <= ui_in;
            par_q  <= uio_in[1];
            tx     <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= data_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx != LAST_BIT) begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_q[bit_idx + 3'd1];
            end else if (par_q) begin
              state <= S_PARITY;
              tx    <= ^data_q;
            end else begin
              state <= S_STOP;
              tx    <= 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    uo_out           = '0;
    uo_out[TX_BIT]   = tx;
    uo_out[BUSY_BIT] = busy;
    uo_out[DONE_BIT] = done;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_alu_uart_tx.sv
// Bench for tt_um_alu_uart_tx with CLKS_PER_BIT=4.
// Expected frames come from a bit-list model of the serial format.
module tb_tt_um_alu_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] nd;
  logic       np;

  tt_um_alu_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle", uo_out, 8'h01);
    end
  endtask

  // Caller raises uio_in[0] at a negedge before calling
  // (lead=1); with lead=0 the previous chained frame already
  // consumed the synchronizer latency.
  task automatic frame(input logic [7:0] d,
                       input logic       p,
                       input int         hold,
                       input bit         lead,
                       input bit         interfere,
                       input bit         chain,
                       input int         abort_k);
    bit bits[$];
    int c;
    int total;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (p) bits.push_back(^d);
    bits.push_back(1'b1);
    total = bits.size() * CPB;
    c = lead ? 0 : 2;
    if (lead) begin
      repeat (2) begin
        @(negedge clk);
        c++;
        chk("lead", uo_out, 8'h01);
        if (c == hold) uio_in[0] = 1'b0;
      end
    end
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      c++;
      chk("frame", uo_out,
          {5'b0, 1'b0, 1'b1, bits[k / CPB]});
      if (c == hold) uio_in[0] = 1'b0;
      if (k == 0) begin
        ui_in      = 8'($urandom);
        uio_in[1]  = 1'($urandom);
      end
      if (interfere && k == 13) begin
        ui_in     = 8'hFF;
        uio_in[1] = ~p;
        uio_in[0] = 1'b1;
      end
      if (interfere && k == 15) uio_in[0] = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("abort", uo_out, 8'h01);
        return;
      end
      if (chain && k == total - 2) begin
        uio_in[0] = 1'b1;
        ui_in     = nd;
        uio_in[1] = np;
      end
    end
    @(negedge clk);
    chk("done", uo_out, 8'h05);
    if (chain) uio_in[0] = 1'b0;
  endtask

  task automatic launch(input logic [7:0] d, input logic p);
    ui_in     = d;
    uio_in[1] = p;
    uio_in[0] = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic       p;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;

    // reset with random inputs
    repeat (5) begin
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      chk("rst_uo", uo_out, 8'h01);
      chk("rst_uio_out", uio_out, 8'h00);
      chk("rst_uio_oe", uio_oe, 8'h00);
    end
    @(negedge clk);
    uio_in = '0;
    rst_n  = 1'b1;
    idle(3);

    // 0xA5 without parity
    launch(8'hA5, 1'b0);
    frame(8'hA5, 1'b0, 2, 1, 0, 0, -1);
    idle(3);

    // 0x07 with parity
    launch(8'h07, 1'b1);
    frame(8'h07, 1'b1, 2, 1, 0, 0, -1);
    idle(3);

    // interference during DATA
    d = 8'($urandom_range(0, 254));
    p = 1'($urandom);
    launch(d, p);
    frame(d, p, 2, 1, 1, 0, -1);
    idle(12);

    // reset during data bit 3
    d = 8'($urandom);
    launch(d, 1'b0);
    frame(d, 1'b0, 2, 1, 0, 0, 17);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold", uo_out, 8'h01);
    end
    rst_n = 1'b1;
    idle(3);
    launch(8'h3C, 1'b0);
    frame(8'h3C, 1'b0, 2, 1, 0, 0, -1);
    idle(3);

    // random frames
    repeat (6) begin
      d = 8'($urandom);
      p = 1'($urandom);
      launch(d, p);
      frame(d, p, int'($urandom_range(1, 6)), 1, 0, 0, -1);
      idle(int'($urandom_range(1, 5)));
    end

    // start held high for 100 cycles
    d = 8'($urandom);
    p = 1'($urandom);
    launch(d, p);
    frame(d, p, 0, 1, 0, 0, -1);
    idle(p ? 57 - 4 : 57);
    uio_in[0] = 1'b0;
    idle(6);

    // back-to-back: edge lands in the done cycle
    d  = 8'($urandom);
    p  = 1'($urandom);
    nd = 8'($urandom);
    np = 1'($urandom);
    launch(d, p);
    frame(d, p, 2, 1, 0, 1, -1);
    frame(nd, np, 0, 0, 0, 0, -1);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_um_alu_uart_tx.md
TT_UM_ALU_UART_TX -- requirements
Module: tt_um_alu_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, meaning clk cycles per serial bit; legal range 2..255.
REQ-002 Port clk  input  1  system clock, all state on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port ena  input  1  design-powered flag, functionally ignored.
REQ-005 Port ui_in  input  8  ALU result byte to transmit.
REQ-006 Port uio_in  input  8  bit0 = start request (asynchronous pin); bit1 = parity_en (even parity); bits7:2 unused.
REQ-007 Port uo_out  output  8  bit0 = tx serial line (idle high); bit1 = busy; bit2 = done; bits7:3 = 0.
REQ-008 Port uio_out  output  8  constant 0.
REQ-009 Port uio_oe  output  8  constant 0, so all uio pins are inputs.

Function
REQ-010 uio_in[0] SHALL pass through a two-flop synchronizer followed by rising-edge detection; only a detected edge is a start event.
REQ-011 A start event SHALL be accepted only in state IDLE; start events in any other state are dropped, not queued.
REQ-012 On acceptance, ui_in and uio_in[1] SHALL be latched; later changes on these pins SHALL NOT affect the frame in flight.
REQ-013 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP with transitions IDLE->START (accept), START->DATA, DATA->DATA (8 bits), DATA->PARITY (parity_en=1) or DATA->STOP (parity_en=0), PARITY->STOP, STOP->IDLE.
REQ-014 tx SHALL be 0 in START, data bit LSB-first in DATA, XOR of the 8 latched bits in PARITY, and 1 in STOP and IDLE.
REQ-015 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter counting 0..CLKS_PER_BIT-1 and cleared on every state change.
REQ-016 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity.
REQ-017 tx SHALL fall at the third rising clk edge after the first edge that samples uio_in[0] high while in IDLE.
REQ-018 busy SHALL be 1 from the edge on which tx falls through the last cycle of STOP, and 0 otherwise.
REQ-019 done SHALL be a single-cycle pulse on the first IDLE cycle after STOP, coincident with busy falling.
REQ-020 A start edge during that done cycle SHALL be accepted, giving back-to-back frames with no idle gap beyond the synchronizer latency.
REQ-021 uio_in[0] held high continuously SHALL produce exactly one frame.
REQ-022 All outputs SHALL be driven directly from registers, with no combinational path from input to output.

Reset
REQ-023 While rst_n=0: state IDLE, tx=1, busy=0, done=0, counters and synchronizer cleared, uo_out=8'h01.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), and the next start after release SHALL produce a complete, correct frame.

Structure
REQ-025 Package alu_tx_pkg SHALL hold the state enum typedef and constants DATA_BITS=8 and the output bit indices TX_BIT=0, BUSY_BIT=1, DONE_BIT=2.
REQ-026 Sub-module start_sync SHALL contain the two-flop synchronizer and the rising-edge detector; all other logic resides in the top module.
REQ-027 The baud counter width SHALL be 8 bits, and the data bit index SHALL be 3 bits.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset: hold rst_n=0 for 5 cycles with random inputs -> uo_out=8'h01, uio_out=0, uio_oe=0 throughout.
REQ-029 Byte 0xA5, parity off: ui_in=8'hA5, pulse uio_in[0] -> tx emits 0,1,0,1,0,0,1,0,1,1 at 4 cycles each; busy high for 40 cycles; one done pulse.
REQ-030 Byte 0x07, parity on: uio_in[1]=1 -> data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop; frame is 44 cycles.
REQ-031 Interference: change ui_in to 8'hFF and re-pulse start during DATA -> transmitted bits remain those of the latched byte; exactly one frame is sent.
REQ-032 Mid-frame reset: assert rst_n=0 during bit 3 -> tx=1 and busy=0 in the same cycle; after release, sending 0x3C -> frame is correct.
REQ-033 Start held high for 100 cycles -> exactly one frame and one done pulse; a fresh edge issued during the done cycle starts a second frame.
